data_register_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `data_register` instance among `N_REQ` requesters (e.g. MDU result writeback, `mthi`/`mtlo` path, exception/CP0 writes). It samples requests on the rising edge. It registers a one-hot grant and drives `reg_we`/`reg_wdata` during the following cycle, so the falling-edge register captures the winner's data mid-cycle. An optional lock lets one requester keep the port for multi-cycle bursts.

---
 rtl/data_register_arbiter_if.sv | 28 ++
 rtl/data_register_arbiter.sv | 111 +++++++++++
 tb/tb_data_register_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/data_register_arbiter_if.sv
// Write-port bundle between the requesters and the data_register_arbiter.
// master = requester side, slave = arbiter side.
interface data_register_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    reg_we;
    logic [DATA_W-1:0]       reg_wdata;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;

    modport master (
        output req, lock, wdata,
        input  gnt, ack, reg_we, reg_wdata, busy, grant_id
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, ack, reg_we, reg_wdata, busy, grant_id
    );
endinterface

// File: rtl/data_register_arbiter.sv
// Round-robin write-port arbiter sharing one falling-edge data_register among N_REQ requesters.
// Define ARB_TIMEOUT_EN to bound locked bursts to MAX_HOLD+1 consecutive writes.
module data_register_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    data_register_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1) begin : g_bad_params
        $error("data_register_arbiter: unsupported N_REQ or MAX_HOLD");
    end

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t            state;
    logic [N_REQ-1:0]  gnt_reg;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   pick;
    logic              busy;
    logic              keep;
    logic              timeout;
    logic              we;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;
    assign timeout = (state == HOLD) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    // First requester at or above start, wrapping at N_REQ-1.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(start) + i) % N_REQ;
            if (!found && r[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] w);
        return (w == LAST_ID) ? '0 : w + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [ID_W-1:0] w);
        return {{(N_REQ-1){1'b0}}, 1'b1} << w;
    endfunction

    assign pick = rr_pick(bus.req, ptr);
    assign busy = (state != IDLE);
    assign keep = busy && bus.lock[id_reg] && bus.req[id_reg] && !timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt_reg <= '0;
            id_reg  <= '0;
            ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else if (keep) begin
            state <= HOLD;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
`endif
        end else if (|bus.req) begin
            // ptr already sits past the previous winner, so it re-wins only when alone.
            state   <= GRANT;
            gnt_reg <= one_hot(pick);
            id_reg  <= pick;
            ptr     <= next_id(pick);
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state   <= IDLE;
            gnt_reg <= '0;
            id_reg  <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end
    end

    // A winner that drops req inside its cycle suppresses the write.
    assign we            = busy && bus.req[id_reg];
    assign bus.reg_we    = we;
    assign bus.ack       = we ? (gnt_reg & bus.req) : '0;
    assign bus.reg_wdata = bus.wdata[int'(id_reg)*DATA_W +: DATA_W];
    assign bus.gnt       = gnt_reg;
    assign bus.busy      = busy;
    assign bus.grant_id  = id_reg;

endmodule

// File: tb/tb_data_register_arbiter.sv
// Directed bench for data_register_arbiter with a falling-edge register model on its write port.
module tb_data_register_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] reg_q;

    data_register_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus ();

    data_register_arbiter #(.N_REQ(4), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the attached data_register: captures on the falling edge, cleared by reset.
    always_ff @(negedge clock or posedge reset) begin
        if (reset)            reg_q <= '0;
        else if (bus.reg_we)  reg_q <= bus.reg_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic setup();
        @(negedge clock);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        bus.wdata[i*32 +: 32] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b1111;
        bus.lock = 4'b0000;
        bus.wdata = '0;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected %b", bus.ack, 4'b0000); end
        checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.reg_we); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.grant_id); end
        checks++; if (reg_q !== 32'h0) begin errors++; $display("FAIL reset_reg: got %h expected 0", reg_q); end
        setup();
        bus.req = 4'b0000;
        reset = 1'b0;
    endtask

    task automatic test_single();
        set_word(0, 32'h1111_1111);
        set_word(1, 32'h2222_2222);
        set_word(2, 32'hDEAD_BEEF);
        set_word(3, 32'h4444_4444);
        bus.req = 4'b0100;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected %b", bus.gnt, 4'b0100); end
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected %b", bus.ack, 4'b0100); end
        checks++; if (bus.reg_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", bus.reg_we); end
        checks++; if (bus.reg_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h expected deadbeef", bus.reg_wdata); end
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", bus.grant_id); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        setup();
        checks++; if (reg_q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_reg: got %h expected deadbeef", reg_q); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_idle_ack: got %b expected 0000", bus.ack); end
        setup();
    endtask

    task automatic test_round_robin();
        logic [31:0] words [4];
        logic [3:0]  eg;
        words = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, words[i]);
        bus.req = 4'b1111;
        bus.lock = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            eg = 4'b0001 << (i % 4);
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.gnt, eg); end
            checks++; if (bus.ack !== eg) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, bus.ack, eg); end
            checks++; if (bus.reg_wdata !== words[i % 4]) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", i, bus.reg_wdata, words[i % 4]); end
            setup();
            checks++; if (reg_q !== words[i % 4]) begin errors++; $display("FAIL rr_reg[%0d]: got %h expected %h", i, reg_q, words[i % 4]); end
        end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", bus.busy); end
        setup();
    endtask

    task automatic test_lock_burst();
        logic [31:0] exp;
        set_word(3, 32'h3333_0003);
        bus.req = 4'b1010;
        bus.lock = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            exp = 32'hB000_0000 + 32'(i);
            set_word(1, exp);
            tick();
            checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected 0010", i, bus.gnt); end
            checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL lock_ack[%0d]: got %b expected 0010", i, bus.ack); end
            checks++; if (bus.reg_wdata !== exp) begin errors++; $display("FAIL lock_wdata[%0d]: got %h expected %h", i, bus.reg_wdata, exp); end
            setup();
            checks++; if (reg_q !== exp) begin errors++; $display("FAIL lock_reg[%0d]: got %h expected %h", i, reg_q, exp); end
        end
        bus.req = 4'b1000;
        bus.lock = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL lock_next_gnt: got %b expected 1000", bus.gnt); end
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL lock_next_ack: got %b expected 1000", bus.ack); end
        setup();
        checks++; if (reg_q !== 32'h3333_0003) begin errors++; $display("FAIL lock_next_reg: got %h expected 33330003", reg_q); end
        bus.req = 4'b0000;
        tick();
        setup();
    endtask

    task automatic test_withdrawn();
        set_word(0, 32'hC0C0_C0C0);
        set_word(1, 32'hC1C1_C1C1);
        bus.req = 4'b0011;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL wd_gnt: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0010;
        #1;
        checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL wd_we: got %b expected 0", bus.reg_we); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL wd_ack: got %b expected 0000", bus.ack); end
        setup();
        checks++; if (reg_q !== 32'h3333_0003) begin errors++; $display("FAIL wd_reg_kept: got %h expected 33330003", reg_q); end
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wd_next_gnt: got %b expected 0010", bus.gnt); end
        checks++; if (bus.reg_wdata !== 32'hC1C1_C1C1) begin errors++; $display("FAIL wd_next_wdata: got %h expected c1c1c1c1", bus.reg_wdata); end
        setup();
        checks++; if (reg_q !== 32'hC1C1_C1C1) begin errors++; $display("FAIL wd_next_reg: got %h expected c1c1c1c1", reg_q); end
        bus.req = 4'b0000;
        tick();
        setup();
    endtask

    task automatic test_mid_burst_reset();
        set_word(1, 32'hE1E1_E1E1);
        set_word(2, 32'hD2D2_D2D2);
        set_word(3, 32'hD3D3_D3D3);
        bus.req = 4'b1100;
        bus.lock = 4'b0100;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL mr_grant: got %b expected 0100", bus.gnt); end
        setup();
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL mr_hold: got %b expected 0100", bus.gnt); end
        reset = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL mr_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL mr_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL mr_we: got %b expected 0", bus.reg_we); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", bus.busy); end
        checks++; if (reg_q !== 32'h0) begin errors++; $display("FAIL mr_reg: got %h expected 0", reg_q); end
        setup();
        reset = 1'b0;
        bus.req = 4'b1010;
        bus.lock = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mr_first_gnt: got %b expected 0010", bus.gnt); end
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL mr_first_id: got %0d expected 1", bus.grant_id); end
        setup();
        checks++; if (reg_q !== 32'hE1E1_E1E1) begin errors++; $display("FAIL mr_first_reg: got %h expected e1e1e1e1", reg_q); end
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_withdrawn();
        test_mid_burst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
